// File: rtl/rs485_link_ctrl.sv
// Half-duplex RS-485 bus sequencer: round-robin between two byte requesters,
// quiet-bus detection, DE/RE_n guard times and one-byte-at-a-time transmitter feed.
module rs485_link_ctrl #(
    parameter int BIT_CYC    = 2604,
    parameter int IDLE_BITS  = 12,
    parameter int SETUP_BITS = 1,
    parameter int HOLD_BITS  = 1,
    parameter int ABORT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_vld,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_rdy,
    input  logic       req1_vld,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_rdy,
    input  logic       rx_line,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       de,
    output logic       re_n,
    output logic [1:0] grant,
    output logic       frame_abort
);

    localparam int QUIET_CYC = IDLE_BITS * BIT_CYC;
    localparam int SETUP_CYC = SETUP_BITS * BIT_CYC;
    localparam int HOLD_CYC  = HOLD_BITS * BIT_CYC;
    localparam int ABORT_CYC = ABORT_BITS * BIT_CYC;
    localparam int MAX_A     = (QUIET_CYC > SETUP_CYC) ? QUIET_CYC : SETUP_CYC;
    localparam int MAX_B     = (HOLD_CYC > ABORT_CYC) ? HOLD_CYC : ABORT_CYC;
    localparam int MAX_CYC   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW        = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] QUIET_MAX = CW'(QUIET_CYC);
    localparam logic [CW-1:0] SETUP_END = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] HOLD_END  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] ABORT_END = CW'(ABORT_CYC - 1);
    localparam logic [CW-1:0] TIMER_SAT = {CW{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_NEXT      = 3'd4,
        ST_HOLD      = 3'd5
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   timer_r;
    logic [CW-1:0]   quiet_cnt_r;
    logic            de_r;
    logic [1:0]      grant_r;
    logic            prefer1_r;
    logic            last_r;

    logic            timer_clr_s;
    logic            de_nxt_s;
    logic [1:0]      grant_nxt_s;
    logic            prefer1_nxt_s;
    logic            abort_s;
    logic            quiet_s;
    logic            gnt_vld_s;
    logic [7:0]      gnt_data_s;
    logic            gnt_last_s;
    logic            send_s;

    assign quiet_s = (quiet_cnt_r == QUIET_MAX);
    assign send_s  = (state_r == ST_SEND);

    // Select the granted requester's byte stream.
    always_comb begin
        gnt_vld_s  = 1'b0;
        gnt_data_s = 8'h00;
        gnt_last_s = 1'b0;
        if (grant_r[0]) begin
            gnt_vld_s  = req0_vld;
            gnt_data_s = req0_data;
            gnt_last_s = req0_last;
        end else if (grant_r[1]) begin
            gnt_vld_s  = req1_vld;
            gnt_data_s = req1_data;
            gnt_last_s = req1_last;
        end else begin
            gnt_vld_s  = 1'b0;
        end
    end

    // Next-state, grant and DE decisions.
    always_comb begin
        state_nxt_s   = state_r;
        timer_clr_s   = 1'b0;
        de_nxt_s      = de_r;
        grant_nxt_s   = grant_r;
        prefer1_nxt_s = prefer1_r;
        abort_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (quiet_s && (req0_vld || req1_vld)) begin
                    state_nxt_s = ST_SETUP;
                    timer_clr_s = 1'b1;
                    de_nxt_s    = 1'b1;
                    if (req0_vld && req1_vld) begin
                        grant_nxt_s = prefer1_r ? 2'b10 : 2'b01;
                    end else if (req0_vld) begin
                        grant_nxt_s = 2'b01;
                    end else begin
                        grant_nxt_s = 2'b10;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (timer_r == SETUP_END) begin
                    state_nxt_s = ST_SEND;
                    timer_clr_s = 1'b1;
                end else begin
                    state_nxt_s = ST_SETUP;
                end
            end
            ST_SEND: begin
                state_nxt_s = ST_WAIT_DONE;
                timer_clr_s = 1'b1;
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    state_nxt_s = last_r ? ST_HOLD : ST_NEXT;
                    timer_clr_s = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_NEXT: begin
                // The owner keeps the bus between bytes; a long stall gives it up.
                if (gnt_vld_s) begin
                    state_nxt_s = ST_SEND;
                    timer_clr_s = 1'b1;
                end else if (timer_r == ABORT_END) begin
                    state_nxt_s = ST_HOLD;
                    timer_clr_s = 1'b1;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_NEXT;
                end
            end
            ST_HOLD: begin
                if (timer_r == HOLD_END) begin
                    state_nxt_s   = ST_IDLE;
                    timer_clr_s   = 1'b1;
                    de_nxt_s      = 1'b0;
                    grant_nxt_s   = 2'b00;
                    prefer1_nxt_s = grant_r[0];
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                timer_clr_s = 1'b1;
                de_nxt_s    = 1'b0;
                grant_nxt_s = 2'b00;
            end
        endcase
    end

    // State, ownership and frame-end registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            de_r      <= 1'b0;
            grant_r   <= 2'b00;
            prefer1_r <= 1'b0;
            last_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            de_r      <= de_nxt_s;
            grant_r   <= grant_nxt_s;
            prefer1_r <= prefer1_nxt_s;
            if (send_s) begin
                last_r <= gnt_last_s;
            end
        end
    end

    // Guard/stall timer, restarted on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= '0;
        end else if (timer_clr_s) begin
            timer_r <= '0;
        end else if (timer_r != TIMER_SAT) begin
            timer_r <= timer_r + CW'(1);
        end
    end

    // Quiet-bus counter; our own transmission never counts as quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quiet_cnt_r <= '0;
        end else if (!rx_line || de_r) begin
            quiet_cnt_r <= '0;
        end else if (quiet_cnt_r != QUIET_MAX) begin
            quiet_cnt_r <= quiet_cnt_r + CW'(1);
        end
    end

    assign de          = de_r;
    assign re_n        = de_r;
    assign grant       = grant_r;
    assign tx_start    = send_s;
    assign tx_data     = send_s ? gnt_data_s : 8'h00;
    assign req0_rdy    = send_s && grant_r[0] && req0_vld;
    assign req1_rdy    = send_s && grant_r[1] && req1_vld;
    assign frame_abort = abort_s;

endmodule

// File: tb/tb_rs485_link_ctrl.sv
// Directed bench for rs485_link_ctrl at a shortened bit time (4 clk/bit);
// a transmitter model answers each tx_start with tx_done 10 cycles later.
module tb_rs485_link_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req0_vld, req0_last, req0_rdy;
    logic [7:0] req0_data;
    logic       req1_vld, req1_last, req1_rdy;
    logic [7:0] req1_data;
    logic       rx_line;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       de, re_n, frame_abort;
    logic [1:0] grant;

    rs485_link_ctrl #(
        .BIT_CYC(4), .IDLE_BITS(2), .SETUP_BITS(1), .HOLD_BITS(1), .ABORT_BITS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_vld(req0_vld), .req0_data(req0_data), .req0_last(req0_last), .req0_rdy(req0_rdy),
        .req1_vld(req1_vld), .req1_data(req1_data), .req1_last(req1_last), .req1_rdy(req1_rdy),
        .rx_line(rx_line), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .de(de), .re_n(re_n), .grant(grant), .frame_abort(frame_abort)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_at = -100;
    bit stray_done = 1'b0;
    bit took0, took1;
    bit de_q = 1'b0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int st_cyc[$];
    int st_data[$];
    int st_gnt[$];
    int rise_cyc[$];
    int rise_gnt[$];
    int fall_cyc[$];
    int abort_cyc[$];
    int rdy_cnt = 0;
    int rdy_wrong = 0;
    int overlap = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Transmitter model: done pulse 10 cycles after each start, plus injected strays.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_done = (cyc == done_at) || stray_done;
        end
    end

    initial begin
        req0_vld = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        forever begin
            @(negedge clk);
            took0 = req0_rdy;
            @(posedge clk);
            #1;
            if (took0 && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                req0_vld = 1'b1; req0_data = q0[0][7:0]; req0_last = q0[0][8];
            end else begin
                req0_vld = 1'b0;
            end
        end
    end

    initial begin
        req1_vld = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
        forever begin
            @(negedge clk);
            took1 = req1_rdy;
            @(posedge clk);
            #1;
            if (took1 && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                req1_vld = 1'b1; req1_data = q1[0][7:0]; req1_last = q1[0][8];
            end else begin
                req1_vld = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            st_cyc.push_back(cyc);
            st_data.push_back(int'(tx_data));
            st_gnt.push_back(int'(grant));
            done_at = cyc + 10;
            if (!de) overlap++;
        end
        if (frame_abort) abort_cyc.push_back(cyc);
        if (de && !de_q) begin
            rise_cyc.push_back(cyc);
            rise_gnt.push_back(int'(grant));
        end
        if (!de && de_q) fall_cyc.push_back(cyc);
        de_q = de;
        if (req0_rdy) rdy_cnt++;
        if (req1_rdy) rdy_cnt++;
        if ((req0_rdy && !grant[0]) || (req1_rdy && !grant[1])) rdy_wrong++;
    end

    initial begin
        int r, h, sb, rb, fb, ab;
        rst_n = 1'b0;
        rx_line = 1'b1;
        step(3);
        check("rst_de", int'(de), 0);
        check("rst_re_n", int'(re_n), 0);
        check("rst_grant", int'(grant), 0);
        check("rst_tx_start", int'(tx_start), 0);
        check("rst_abort", int'(frame_abort), 0);

        // 1: single two-byte frame from req0
        q0.push_back({1'b0, 8'hA5});
        q0.push_back({1'b1, 8'h3C});
        sb = st_cyc.size(); rb = rise_cyc.size(); fb = fall_cyc.size();
        step(1);
        rst_n = 1'b1;
        r = cyc;
        step(60);
        check("t1_de_rise", rise_cyc[rb] - r, 9);
        check("t1_setup", st_cyc[sb] - rise_cyc[rb], 4);
        check("t1_byte0", st_data[sb], 8'hA5);
        check("t1_byte1", st_data[sb+1], 8'h3C);
        check("t1_gap", st_cyc[sb+1] - st_cyc[sb], 12);
        check("t1_hold", fall_cyc[fb] - st_cyc[sb+1], 15);
        check("t1_grant_end", int'(grant), 0);

        // 2: busy bus holds req1 off until a full quiet window
        rb = rise_cyc.size(); sb = st_cyc.size();
        rx_line = 1'b0;
        q1.push_back({1'b1, 8'h77});
        for (int k = 0; k < 5; k++) begin
            step(1); rx_line = 1'b1;
            step(5); rx_line = 1'b0;
        end
        step(1);
        rx_line = 1'b1;
        h = cyc;
        check("t2_busy_no_de", rise_cyc.size() - rb, 0);
        step(40);
        check("t2_de_rise", rise_cyc[rb] - h, 9);
        check("t2_grant", rise_gnt[rb], 2);
        check("t2_byte", st_data[sb], 8'h77);

        // 3: both requesters, one-byte frames, alternate ownership
        sb = st_cyc.size();
        q0.push_back({1'b1, 8'h01});
        q0.push_back({1'b1, 8'h02});
        q1.push_back({1'b1, 8'h81});
        q1.push_back({1'b1, 8'h82});
        step(150);
        check("t3_gnt0", st_gnt[sb], 1);
        check("t3_gnt1", st_gnt[sb+1], 2);
        check("t3_gnt2", st_gnt[sb+2], 1);
        check("t3_gnt3", st_gnt[sb+3], 2);
        check("t3_data0", st_data[sb], 8'h01);
        check("t3_data1", st_data[sb+1], 8'h81);
        check("t3_data2", st_data[sb+2], 8'h02);
        check("t3_data3", st_data[sb+3], 8'h82);

        // 4: owner stalls mid-frame
        sb = st_cyc.size(); ab = abort_cyc.size(); fb = fall_cyc.size();
        q0.push_back({1'b0, 8'h11});
        step(50);
        check("t4_byte", st_data[sb], 8'h11);
        check("t4_abort_at", abort_cyc[ab] - st_cyc[sb], 22);
        check("t4_hold", fall_cyc[fb] - abort_cyc[ab], 5);

        // 5: reset while waiting for tx_done
        sb = st_cyc.size();
        q0.push_back({1'b1, 8'h22});
        for (int k = 0; k < 40; k++) begin
            if (st_cyc.size() > sb) break;
            step(1);
        end
        check("t5_start_seen", int'(st_cyc.size() > sb), 1);
        step(3);
        rst_n = 1'b0;
        #1;
        check("t5_de_async", int'(de), 0);
        check("t5_re_n_async", int'(re_n), 0);
        check("t5_grant_async", int'(grant), 0);
        step(2);
        rst_n = 1'b1;
        r = cyc;
        sb = st_cyc.size();
        q1.push_back({1'b1, 8'h44});
        step(40);
        check("t5_restart", st_cyc[sb] - r, 13);
        check("t5_byte", st_data[sb], 8'h44);

        // 6: stray tx_done in IDLE and in SETUP
        stray_done = 1'b1;
        step(1);
        stray_done = 1'b0;
        sb = st_cyc.size(); rb = rise_cyc.size();
        q0.push_back({1'b0, 8'h55});
        q0.push_back({1'b1, 8'h66});
        for (int k = 0; k < 20; k++) begin
            if (rise_cyc.size() > rb) break;
            step(1);
        end
        stray_done = 1'b1;
        step(1);
        stray_done = 1'b0;
        step(60);
        check("t6_setup", st_cyc[sb] - rise_cyc[rb], 4);
        check("t6_byte0", st_data[sb], 8'h55);
        check("t6_byte1", st_data[sb+1], 8'h66);

        check("tot_starts", st_cyc.size(), 12);
        check("tot_rdy", rdy_cnt, 12);
        check("rdy_not_owner", rdy_wrong, 0);
        check("start_without_de", overlap, 0);
        check("tot_aborts", abort_cyc.size(), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
